// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISS  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;

    function automatic logic is_hlt(input logic [15:0] instr);
        return (instr[15:12] == HLT_OPCODE);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'h0001);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: synchronous reset, bubble insertion and write-enable, in that priority.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              bubble_i,
    input  logic [15:0]       instr_i,
    input  logic [ADDR_W-1:0] pc_plus2_i,
    output logic [15:0]       instr_o,
    output logic [ADDR_W-1:0] pc_plus2_o,
    output logic              valid_o
);

    logic [15:0]       instr_q;
    logic [ADDR_W-1:0] pc_plus2_q;
    logic              valid_q;

    // Pipeline register update; a bubble clears the instruction and keeps the stale pc_plus2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= {ADDR_W{1'b0}};
            valid_q    <= 1'b0;
        end else if (bubble_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= pc_plus2_q;
            valid_q    <= 1'b0;
        end else if (we_i) begin
            instr_q    <= instr_i;
            pc_plus2_q <= pc_plus2_i;
            valid_q    <= 1'b1;
        end else begin
            instr_q    <= instr_q;
            pc_plus2_q <= pc_plus2_q;
            valid_q    <= valid_q;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with miss tolerance, stall/freeze/flush handling and HLT detection.
// Optional FETCH_PERF_CNT_EN adds saturating miss_cycles and flush_count outputs.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              mem_stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic [15:0]       icache_rdata,
    input  logic              icache_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       IF_ID_instr,
    output logic [ADDR_W-1:0] IF_ID_pc_plus2,
    output logic              IF_ID_valid,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       miss_cycles,
    output logic [15:0]       flush_count
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2'd2);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              drop_q, drop_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] cur_addr_s;
    logic              hlt_s;
    fetch_state_e      hit_state_s;
    logic [ADDR_W-1:0] hit_pc_s;
    logic              ifid_we_s;
    logic              ifid_bubble_s;

    // While a miss is outstanding the cache keeps seeing the latched address, even after a redirect.
    assign cur_addr_s  = (state_q == MISS) ? fetch_addr_q : pc_q;
    assign icache_addr = cur_addr_s;
    assign icache_req  = ~rst & (state_q != HALT);
    assign pc          = pc_q;
    assign halted      = halted_q;

    // Outcome of accepting the word on the bus: HLT parks the PC on itself.
    always_comb begin
        hlt_s = is_hlt(icache_rdata);
        if (hlt_s) begin
            hit_state_s = HALT;
            hit_pc_s    = cur_addr_s;
        end else begin
            hit_state_s = FETCH;
            hit_pc_s    = cur_addr_s + PC_STEP;
        end
    end

    // Next-state logic; priority is mem_stall > flush > stall > normal fetch.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_addr_d  = fetch_addr_q;
        drop_d        = drop_q;
        halted_d      = halted_q;
        ifid_we_s     = 1'b0;
        ifid_bubble_s = 1'b0;

        if (mem_stall) begin
            state_d = state_q;
        end else if (flush) begin
            ifid_bubble_s = 1'b1;
            pc_d          = branch_target;
            halted_d      = 1'b0;
            if ((state_q == MISS) && !icache_valid) begin
                state_d = MISS;
                drop_d  = 1'b1;
            end else begin
                state_d = FETCH;
                drop_d  = 1'b0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (icache_valid && !stall) begin
                        ifid_we_s = 1'b1;
                        pc_d      = hit_pc_s;
                        state_d   = hit_state_s;
                        halted_d  = hlt_s;
                    end else if (!icache_valid) begin
                        state_d       = MISS;
                        fetch_addr_d  = pc_q;
                        ifid_bubble_s = ~stall;
                    end else begin
                        state_d = FETCH;
                    end
                end
                MISS: begin
                    if (drop_q) begin
                        ifid_bubble_s = ~stall;
                        if (icache_valid) begin
                            state_d = FETCH;
                            drop_d  = 1'b0;
                        end else begin
                            state_d = MISS;
                        end
                    end else if (icache_valid && !stall) begin
                        ifid_we_s = 1'b1;
                        pc_d      = hit_pc_s;
                        state_d   = hit_state_s;
                        halted_d  = hlt_s;
                    end else begin
                        state_d       = MISS;
                        ifid_bubble_s = ~stall;
                    end
                end
                HALT: begin
                    state_d       = HALT;
                    ifid_bubble_s = ~stall;
                end
                default: begin
                    state_d       = FETCH;
                    ifid_bubble_s = 1'b1;
                end
            endcase
        end
    end

    // Control and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            drop_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_q       <= drop_d;
            halted_q     <= halted_d;
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id (
        .clk_i      (clk),
        .rst_i      (rst),
        .we_i       (ifid_we_s),
        .bubble_i   (ifid_bubble_s),
        .instr_i    (icache_rdata),
        .pc_plus2_i (cur_addr_s + PC_STEP),
        .instr_o    (IF_ID_instr),
        .pc_plus2_o (IF_ID_pc_plus2),
        .valid_o    (IF_ID_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] miss_cycles_q;
    logic [15:0] flush_count_q;

    // Saturating performance counters; a frozen pipeline counts nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cycles_q <= 16'h0000;
            flush_count_q <= 16'h0000;
        end else begin
            if ((state_q == MISS) && !mem_stall) begin
                miss_cycles_q <= sat_inc16(miss_cycles_q);
            end else begin
                miss_cycles_q <= miss_cycles_q;
            end
            if (flush && !mem_stall) begin
                flush_count_q <= sat_inc16(flush_count_q);
            end else begin
                flush_count_q <= flush_count_q;
            end
        end
    end

    assign miss_cycles = miss_cycles_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then randomized traffic against a stream scoreboard.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        mem_stall;
    logic        flush;
    logic [15:0] branch_target;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic [15:0] icache_rdata;
    logic        icache_valid;
    logic [15:0] pc;
    logic [15:0] IF_ID_instr;
    logic [15:0] IF_ID_pc_plus2;
    logic        IF_ID_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] miss_cycles;
    logic [15:0] flush_count;
    logic [15:0] fc_before;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W   (16),
        .RESET_PC (16'h0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .mem_stall      (mem_stall),
        .flush          (flush),
        .branch_target  (branch_target),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_rdata   (icache_rdata),
        .icache_valid   (icache_valid),
        .pc             (pc),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pc_plus2 (IF_ID_pc_plus2),
        .IF_ID_valid    (IF_ID_valid),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .miss_cycles    (miss_cycles),
        .flush_count    (flush_count)
`endif
    );

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          popped  = 0;
    bit          sb_en   = 1'b0;
    exp_t        exp_q[$];
    logic [15:0] tbl [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return tbl[a[8:1]];
    endfunction

    // Program-order model: after a redirect the accepted words are consecutive addresses up to an HLT.
    task automatic redirect(input logic [15:0] target);
        logic [15:0] a;
        logic [15:0] w;
        exp_q.delete();
        a = target;
        for (int i = 0; i < 64; i++) begin
            w = mem_word(a);
            exp_q.push_back({w, a + 16'd2});
            if (w[15:12] == 4'hF) break;
            a = a + 16'd2;
        end
    endtask

    // Monitor: each newly latched IF/ID instruction is compared with the head of the expected stream.
    bit          mon_pv  = 1'b0;
    logic [15:0] mon_pp2 = 16'h0000;
    always @(negedge clk) begin
        exp_t e;
        if (sb_en && IF_ID_valid && (!mon_pv || (IF_ID_pc_plus2 != mon_pp2))) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got instr %h pc+2 %h, expected no instruction", IF_ID_instr, IF_ID_pc_plus2);
            end else begin
                e = exp_q.pop_front();
                popped++;
                chk("sb_instr", IF_ID_instr, e.instr);
                chk("sb_pc_plus2", IF_ID_pc_plus2, e.pc_plus2);
                if (e.instr[15:12] == 4'hF) begin
                    chk("sb_halted_set", halted, 1'b1);
                    chk("sb_halt_pc", pc, e.pc_plus2 - 16'd2);
                end else begin
                    chk("sb_not_halted", halted, 1'b0);
                    chk("sb_next_pc", pc, e.pc_plus2);
                end
            end
        end
        mon_pv  = IF_ID_valid;
        mon_pp2 = IF_ID_pc_plus2;
    end

    // Cache model state: a fresh address picks a latency, then the word stays offered until the address moves.
    bit          c_active = 1'b0;
    logic [15:0] c_addr   = 16'h0000;
    int          c_cnt    = 0;
    int          c_lat    = 0;

    task automatic cache_respond();
        logic [15:0] junk;
        if (!icache_req) begin
            c_active     = 1'b0;
            icache_valid = 1'b0;
        end else begin
            if (!c_active || (icache_addr != c_addr)) begin
                c_active = 1'b1;
                c_addr   = icache_addr;
                c_cnt    = 0;
                c_lat    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            end else begin
                c_cnt++;
            end
            icache_valid = (c_cnt >= c_lat);
        end
        junk         = 16'($urandom);
        icache_rdata = icache_valid ? mem_word(icache_addr) : junk;
    endtask

    initial begin
        logic [15:0] r;
        logic        l_rst, l_flush, l_ms, p_req, p_valid, acc_flush;
        logic [15:0] l_tgt, p_addr;
        int          since;

        for (int i = 0; i < 256; i++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                tbl[i] = {4'hF, r[11:0]};
            end else begin
                tbl[i] = {4'($urandom_range(0, 14)), r[11:0]};
            end
        end

        rst = 1'b1; stall = 1'b0; mem_stall = 1'b0; flush = 1'b0;
        branch_target = 16'h0000; icache_rdata = 16'h0000; icache_valid = 1'b0;
        #1;
        chk("req_low_in_reset", icache_req, 1'b0);
        cyc(); cyc();
        chk("reset_pc", pc, 16'h0100);
        chk("reset_valid", IF_ID_valid, 1'b0);
        chk("reset_instr", IF_ID_instr, 16'h0000);
        chk("reset_pc_plus2", IF_ID_pc_plus2, 16'h0000);
        chk("reset_halted", halted, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset_flush_count", flush_count, 16'h0000);
        chk("reset_miss_cycles", miss_cycles, 16'h0000);
`endif

        // Back-to-back hits.
        rst = 1'b0; icache_valid = 1'b1; icache_rdata = 16'h1111;
        #1;
        chk("req_after_reset", icache_req, 1'b1);
        chk("first_addr", icache_addr, 16'h0100);
        cyc();
        chk("hit1_pc_plus2", IF_ID_pc_plus2, 16'h0102);
        chk("hit1_valid", IF_ID_valid, 1'b1);
        chk("hit1_instr", IF_ID_instr, 16'h1111);
        icache_rdata = 16'h1222;
        cyc();
        chk("hit2_pc_plus2", IF_ID_pc_plus2, 16'h0104);
        chk("hit2_instr", IF_ID_instr, 16'h1222);

        // Three-cycle miss at 0x0104.
        icache_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("miss_bubble", IF_ID_valid, 1'b0);
            chk("miss_addr_stable", icache_addr, 16'h0104);
        end
        icache_valid = 1'b1; icache_rdata = 16'h2222;
        cyc();
        chk("fill_instr", IF_ID_instr, 16'h2222);
        chk("fill_pc_plus2", IF_ID_pc_plus2, 16'h0106);
        chk("fill_pc", pc, 16'h0106);

        // Flush while a miss is outstanding: the fill is discarded.
        icache_valid = 1'b0;
        cyc();
        flush = 1'b1; branch_target = 16'h0200;
        cyc();
        flush = 1'b0;
        chk("miss_flush_pc", pc, 16'h0200);
        chk("miss_flush_bubble", IF_ID_valid, 1'b0);
        chk("miss_flush_old_addr", icache_addr, 16'h0106);
        icache_valid = 1'b1; icache_rdata = 16'h3333;
        cyc();
        chk("dropped_fill", IF_ID_valid, 1'b0);
        chk("redirect_addr", icache_addr, 16'h0200);
        icache_rdata = 16'h4444;
        cyc();
        chk("target_instr", IF_ID_instr, 16'h4444);
        chk("target_pc_plus2", IF_ID_pc_plus2, 16'h0202);

        // Two-cycle stall with the cache hitting.
        stall = 1'b1; icache_rdata = 16'h5555;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_pc_hold", pc, 16'h0202);
            chk("stall_ifid_hold", IF_ID_instr, 16'h4444);
        end
        stall = 1'b0;
        cyc();
        chk("post_stall_instr", IF_ID_instr, 16'h5555);
        chk("post_stall_pc", pc, 16'h0204);

        // HLT, then flush out of HALT.
        icache_rdata = 16'hF000;
        cyc();
        chk("hlt_halted", halted, 1'b1);
        chk("hlt_pc", pc, 16'h0204);
        chk("hlt_req", icache_req, 1'b0);
        cyc();
        chk("halt_pc_hold", pc, 16'h0204);
        chk("halt_bubble", IF_ID_valid, 1'b0);
        flush = 1'b1; branch_target = 16'h0300;
        cyc();
        flush = 1'b0;
        chk("unhalt_flag", halted, 1'b0);
        chk("unhalt_pc", pc, 16'h0300);
        chk("unhalt_req", icache_req, 1'b1);
        icache_rdata = 16'h6666;
        cyc();
        chk("resume_pc_plus2", IF_ID_pc_plus2, 16'h0302);

        // mem_stall together with flush: the flush only lands once the freeze lifts.
`ifdef FETCH_PERF_CNT_EN
        fc_before = flush_count;
`endif
        mem_stall = 1'b1; flush = 1'b1; branch_target = 16'h0400;
        cyc();
        chk("freeze_pc", pc, 16'h0302);
        chk("freeze_ifid_valid", IF_ID_valid, 1'b1);
        chk("freeze_ifid_instr", IF_ID_instr, 16'h6666);
        mem_stall = 1'b0;
        cyc();
        flush = 1'b0;
        chk("unfreeze_pc", pc, 16'h0400);
        chk("unfreeze_bubble", IF_ID_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("flush_count_once", flush_count, fc_before + 16'd1);
`endif

        // Reset in the middle of a miss.
        icache_valid = 1'b0;
        cyc();
        chk("pre_reset_miss_addr", icache_addr, 16'h0400);
        rst = 1'b1;
        cyc();
        chk("midmiss_reset_pc", pc, 16'h0100);
        chk("midmiss_reset_addr", icache_addr, 16'h0100);
        chk("midmiss_reset_req", icache_req, 1'b0);

        // Randomized traffic checked by the stream scoreboard.
        sb_en = 1'b1;
        l_rst = 1'b1; l_flush = 1'b0; l_ms = 1'b0; l_tgt = 16'h0000;
        p_req = 1'b0; p_valid = 1'b1; p_addr = 16'h0000; since = 0;
        for (int c = 0; c < 3000; c++) begin
            acc_flush = l_flush && !l_ms;
            if (l_rst) begin
                redirect(16'h0100);
                since = 0;
            end else if (acc_flush) begin
                redirect(l_tgt);
                since = 0;
            end else begin
                since++;
            end
            if (!l_rst && !acc_flush && p_req && !p_valid) begin
                chk("rand_miss_addr_stable", icache_addr, p_addr);
            end

            rst = (c < 2) || ($urandom_range(0, 599) == 0);
            #1;
            cache_respond();
            stall     = ($urandom_range(0, 5) == 0);
            mem_stall = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0) || (since >= 50);
            r         = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                branch_target = {13'h1FFF, r[1:0], 1'b0};
            end else begin
                branch_target = {r[15:1], 1'b0};
            end

            l_rst = rst; l_flush = flush; l_ms = mem_stall; l_tgt = branch_target;
            p_req = icache_req; p_valid = icache_valid; p_addr = icache_addr;
            cyc();
        end
        @(negedge clk);
        sb_en = 1'b0;
        chk("rand_progress", (popped > 200), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
